mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Turns MemRead/MemWrite into a
//  req/ack transaction on a variable-latency data-memory port. Drives the pipeline
//  stall (upstream en_reg = !stall) and the branch decision (pc_src). Registers the
//  MEM/WB outputs, inserting a bubble while stalled.
// PARAMETERS
//  DATA_W   32   data/address width
//  TIMEOUT  255  max ACCESS cycles without ack before abort (>=1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  MemRead_in   in   1       EX/MEM: load
//  MemWrite_in  in   1       EX/MEM: store
//  Branch_in    in   1       EX/MEM: branch
//  zero_in      in   1       EX/MEM: ALU zero
//  RegWrite_in  in   1       EX/MEM: write-back enable
//  MemtoReg_in  in   1       EX/MEM: WB mux select
//  wn_in        in   5       EX/MEM: destination register
//  alu_in       in   DATA_W  EX/MEM: ALU result / memory address
//  rd2_in       in   DATA_W  EX/MEM: store data
//  dmem_req     out  1       memory request, held until ack
//  dmem_we      out  1       1 = write
//  dmem_addr    out  DATA_W  address (= alu_in while req, else 0)
//  dmem_wdata   out  DATA_W  write data (= rd2_in while req & we, else 0)
//  dmem_rdata   in   DATA_W  read data, valid when dmem_ack
//  dmem_ack     in   1       one-cycle completion strobe
//  stall        out  1       hold EX/MEM and earlier stages
//  pc_src       out  1       branch taken
//  wb_RegWrite  out  1       MEM/WB: write-back enable
//  wb_MemtoReg  out  1       MEM/WB: WB mux select
//  wb_wn        out  5       MEM/WB: destination register
//  wb_rdata     out  DATA_W  MEM/WB: load data
//  wb_alu       out  DATA_W  MEM/WB: ALU result
//  mem_err      out  1       sticky timeout flag
// BEHAVIOUR
//  FSM, states IDLE and ACCESS; reset -> IDLE; all registered outputs reset to 0.
//  IDLE: if MemRead_in|MemWrite_in -> ACCESS, stall=1, req stays 0 this cycle.
//        Otherwise stall=0 and MEM/WB captures EX/MEM fields, with wb_rdata=0.
//  ACCESS: dmem_req=1 (decoded from state, so it falls the cycle after reset or exit).
//        dmem_we=MemWrite_in; when MemRead and MemWrite are both set, write wins.
//        Inputs stay stable because upstream is stalled.
//        Ack cycle: stall=0 in the same cycle. MEM/WB captures control, alu_in and
//          dmem_rdata (rdata only on a load; a store keeps wb_rdata 0). -> IDLE.
//        No ack: stall=1, timeout counter increments.
//        Counter == TIMEOUT-1 with no ack: abort. stall=0, MEM/WB takes a bubble,
//          mem_err<=1 (cleared only by rst), -> IDLE.
//  Minimum memory-op latency 2 cycles (IDLE detect + ACCESS with immediate ack).
//  Bubble while stall=1: wb_RegWrite=0, wb_MemtoReg=0, wb_wn=0; wb_rdata/wb_alu hold.
//  pc_src = Branch_in & zero_in & !stall, combinational.
//  dmem_ack in IDLE is ignored.
//  Counter width $clog2(TIMEOUT+1); cleared on entering ACCESS and on reset.
//  Reset mid-ACCESS: next cycle state=IDLE, req=0, stall follows IDLE rule; a late ack
//    is ignored.
// STRUCTURE
//  Shared mips_pkg: state encoding (ST_IDLE=1'b0, ST_ACCESS=1'b1), BUBBLE control constant.
//  Sub-modules: two reg32 instances for wb_rdata/wb_alu. FSM, counter and control
//    regs stay in this module.
// TESTING
//  1 Load, alu_in=0x40, ack after 3 ACCESS cycles, rdata=0xDEADBEEF -> stall high for
//    4 cycles; wb_rdata=0xDEADBEEF, wb_RegWrite=1, wb_MemtoReg=1 at the ack edge.
//  2 Store, rd2_in=0x1234, ack on first ACCESS cycle -> req/we for 1 cycle,
//    dmem_wdata=0x1234, stall 1 cycle, wb_RegWrite as input.
//  3 Branch_in=1, zero_in=1, no mem op -> pc_src=1, stall=0; zero_in=0 -> pc_src=0.
//  4 TIMEOUT=4, load, never ack -> req high 4 cycles then low; mem_err=1; one bubble.
//  5 rst asserted in 2nd ACCESS cycle, ack one cycle later -> req=0 and IDLE after
//    the reset edge; late ack ignored, all wb_* = 0.
//  6 Back-to-back loads, immediate ack -> each takes 2 cycles; wb_wn order preserved.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MEM-stage types: FSM state encoding and the MEM/WB
//                control bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       memto_reg;
        logic [4:0] wn;
    } wb_ctrl_t;

    localparam wb_ctrl_t BUBBLE = '{reg_write: 1'b0, memto_reg: 1'b0, wn: 5'd0};

endpackage
`default_nettype wire

// File: rtl/reg32.sv
`default_nettype none
// ============================================================================
//  Module      : reg32
//  Description : Enabled data register with synchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM-stage controller: req/ack data-memory access with timeout,
//                pipeline stall, branch decision and MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    input  logic              zero_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic [4:0]        wn_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rd2_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              pc_src,
    output logic              wb_RegWrite,
    output logic              wb_MemtoReg,
    output logic [4:0]        wb_wn,
    output logic [DATA_W-1:0] wb_rdata,
    output logic [DATA_W-1:0] wb_alu,
    output logic              mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    wb_ctrl_t           r_wb_ctrl, w_wb_ctrl_nxt;
    logic               r_mem_err, w_mem_err_nxt;
    logic               w_mem_op;
    logic               w_is_load;
    logic               w_data_en;
    logic [DATA_W-1:0]  w_rdata_d;
    wb_ctrl_t           w_in_ctrl;

    assign w_mem_op  = MemRead_in | MemWrite_in;
    // A simultaneous read+write is treated as a store, so no load data is kept.
    assign w_is_load = MemRead_in & ~MemWrite_in;
    assign w_in_ctrl = '{reg_write: RegWrite_in, memto_reg: MemtoReg_in, wn: wn_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wb_ctrl <= BUBBLE;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wb_ctrl <= w_wb_ctrl_nxt;
            r_mem_err <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wb_ctrl_nxt = BUBBLE;
        w_mem_err_nxt = r_mem_err;
        w_data_en     = 1'b0;
        w_rdata_d     = '0;
        stall         = 1'b0;
        dmem_req      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    stall       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_wb_ctrl_nxt = w_in_ctrl;
                    w_data_en     = 1'b1;
                end
            end
            ST_ACCESS: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_wb_ctrl_nxt = w_in_ctrl;
                    w_data_en     = 1'b1;
                    w_rdata_d     = w_is_load ? dmem_rdata : '0;
                    w_state_nxt   = ST_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    // Abort: release the pipeline and let MEM/WB take a bubble.
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    stall     = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign dmem_we    = dmem_req & MemWrite_in;
    assign dmem_addr  = dmem_req ? alu_in : '0;
    assign dmem_wdata = dmem_we ? rd2_in : '0;
    assign pc_src     = Branch_in & zero_in & ~stall;

    assign wb_RegWrite = r_wb_ctrl.reg_write;
    assign wb_MemtoReg = r_wb_ctrl.memto_reg;
    assign wb_wn       = r_wb_ctrl.wn;
    assign mem_err     = r_mem_err;

    reg32 #(.WIDTH(DATA_W)) u_wb_rdata (
        .clk (clk),
        .rst (rst),
        .en  (w_data_en),
        .d   (w_rdata_d),
        .q   (wb_rdata)
    );

    reg32 #(.WIDTH(DATA_W)) u_wb_alu (
        .clk (clk),
        .rst (rst),
        .en  (w_data_en),
        .d   (alu_in),
        .q   (wb_alu)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed self-checking bench for mem_stage_ctrl (TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              MemRead_in, MemWrite_in, Branch_in, zero_in;
    logic              RegWrite_in, MemtoReg_in;
    logic [4:0]        wn_in;
    logic [DATA_W-1:0] alu_in, rd2_in, dmem_rdata;
    logic              dmem_ack;
    logic              dmem_req, dmem_we, stall, pc_src;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, wb_rdata, wb_alu;
    logic              wb_RegWrite, wb_MemtoReg, mem_err;
    logic [4:0]        wb_wn;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [4:0]  wn;
        logic [31:0] rdata;
        logic [31:0] alu;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      errors = 0;
    int      checks = 0;
    int      nstall;
    int      nreq;

    mem_stage_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .Branch_in   (Branch_in),
        .zero_in     (zero_in),
        .RegWrite_in (RegWrite_in),
        .MemtoReg_in (MemtoReg_in),
        .wn_in       (wn_in),
        .alu_in      (alu_in),
        .rd2_in      (rd2_in),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .stall       (stall),
        .pc_src      (pc_src),
        .wb_RegWrite (wb_RegWrite),
        .wb_MemtoReg (wb_MemtoReg),
        .wb_wn       (wb_wn),
        .wb_rdata    (wb_rdata),
        .wb_alu      (wb_alu),
        .mem_err     (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        Branch_in   = 1'b0;
        zero_in     = 1'b0;
        RegWrite_in = 1'b0;
        MemtoReg_in = 1'b0;
        wn_in       = 5'd0;
        alu_in      = '0;
        rd2_in      = '0;
    endtask

    task automatic push(input logic rw, input logic m2r, input logic [4:0] wn,
                        input logic [31:0] rdata, input logic [31:0] alu);
        wb_exp_t e;
        e.rw = rw; e.m2r = m2r; e.wn = wn; e.rdata = rdata; e.alu = alu;
        sb_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_RegWrite"}, 32'(wb_RegWrite), 32'(e.rw));
            chk({tag, "_MemtoReg"}, 32'(wb_MemtoReg), 32'(e.m2r));
            chk({tag, "_wn"},       32'(wb_wn),       32'(e.wn));
            chk({tag, "_rdata"},    wb_rdata,         e.rdata);
            chk({tag, "_alu"},      wb_alu,           e.alu);
        end
    endtask

    initial begin
        clear_inputs();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check_wb("reset");
        chk("reset_req",     32'(dmem_req), 32'h0);
        chk("reset_stall",   32'(stall),    32'h0);
        chk("reset_mem_err", 32'(mem_err),  32'h0);
        rst = 1'b0;

        // Plain ALU op flows straight into MEM/WB
        RegWrite_in = 1'b1; wn_in = 5'd7; alu_in = 32'h99;
        push(1'b1, 1'b0, 5'd7, 32'h0, 32'h99);
        #1 chk("alu_stall", 32'(stall), 32'h0);
        tick();
        check_wb("alu");

        // Test 1: load, ack on the 4th ACCESS cycle (last before timeout)
        clear_inputs();
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
        wn_in = 5'd5; alu_in = 32'h40; Branch_in = 1'b1; zero_in = 1'b1;
        push(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h40);
        nstall = 0;
        #1;
        chk("t1_idle_stall",  32'(stall),  32'h1);
        chk("t1_idle_req",    32'(dmem_req), 32'h0);
        chk("t1_idle_addr",   dmem_addr,   32'h0);
        chk("t1_idle_pc_src", 32'(pc_src), 32'h0);
        nstall += int'(stall);
        tick();
        chk("t1_bubble_rw",  32'(wb_RegWrite), 32'h0);
        chk("t1_bubble_wn",  32'(wb_wn),       32'h0);
        chk("t1_bubble_alu", wb_alu,           32'h99);
        for (int i = 0; i < 3; i++) begin
            chk("t1_req",  32'(dmem_req), 32'h1);
            chk("t1_addr", dmem_addr,     32'h40);
            chk("t1_we",   32'(dmem_we),  32'h0);
            nstall += int'(stall);
            tick();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_ack_stall",  32'(stall),    32'h0);
        chk("t1_ack_req",    32'(dmem_req), 32'h1);
        chk("t1_ack_pc_src", 32'(pc_src),   32'h1);
        nstall += int'(stall);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        clear_inputs();
        check_wb("t1_wb");
        chk("t1_stall_cycles", 32'(nstall), 32'h4);
        chk("t1_req_fall", 32'(dmem_req), 32'h0);

        // Test 2: store with immediate ack
        MemWrite_in = 1'b1; RegWrite_in = 1'b1; wn_in = 5'd3;
        alu_in = 32'h80; rd2_in = 32'h1234;
        push(1'b1, 1'b0, 5'd3, 32'h0, 32'h80);
        #1;
        chk("t2_idle_stall", 32'(stall),  32'h1);
        chk("t2_idle_wdata", dmem_wdata,  32'h0);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        #1;
        chk("t2_req",   32'(dmem_req), 32'h1);
        chk("t2_we",    32'(dmem_we),  32'h1);
        chk("t2_wdata", dmem_wdata,    32'h1234);
        chk("t2_addr",  dmem_addr,     32'h80);
        chk("t2_stall", 32'(stall),    32'h0);
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        clear_inputs();
        check_wb("t2_wb");
        chk("t2_req_fall", 32'(dmem_req), 32'h0);
        chk("t2_we_fall",  32'(dmem_we),  32'h0);

        // Test 3: branch decision without a memory op
        Branch_in = 1'b1; zero_in = 1'b1; RegWrite_in = 1'b1; wn_in = 5'd2; alu_in = 32'h55;
        #1;
        chk("t3_pc_src_taken", 32'(pc_src), 32'h1);
        chk("t3_stall",        32'(stall),  32'h0);
        zero_in = 1'b0;
        #1 chk("t3_pc_src_not", 32'(pc_src), 32'h0);
        push(1'b1, 1'b0, 5'd2, 32'h0, 32'h55);
        tick();
        check_wb("t3_wb");

        // Test 4: load never acked -> abort after TIMEOUT ACCESS cycles
        clear_inputs();
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1; wn_in = 5'd9; alu_in = 32'h44;
        push(1'b0, 1'b0, 5'd0, 32'h0, 32'h55);
        nreq = 0;
        #1 chk("t4_idle_stall", 32'(stall), 32'h1);
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("t4_stall", 32'(stall), (i < TIMEOUT - 1) ? 32'h1 : 32'h0);
            nreq += int'(dmem_req);
            tick();
        end
        clear_inputs();
        #1;
        chk("t4_req_cycles", 32'(nreq),     32'(TIMEOUT));
        chk("t4_req_fall",   32'(dmem_req), 32'h0);
        chk("t4_mem_err",    32'(mem_err),  32'h1);
        check_wb("t4_bubble");
        tick();
        chk("t4_mem_err_sticky", 32'(mem_err), 32'h1);

        // Test 5: reset during the 2nd ACCESS cycle, ack arrives one cycle later
        MemRead_in = 1'b1; RegWrite_in = 1'b1; wn_in = 5'd4; alu_in = 32'h60;
        tick();
        tick();
        rst = 1'b1;
        #1 chk("t5_req_pre_rst", 32'(dmem_req), 32'h1);
        tick();
        rst = 1'b0;
        clear_inputs();
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        #1;
        chk("t5_req",     32'(dmem_req), 32'h0);
        chk("t5_stall",   32'(stall),    32'h0);
        chk("t5_mem_err", 32'(mem_err),  32'h0);
        push(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check_wb("t5_after_rst");
        tick();
        dmem_ack = 1'b0; dmem_rdata = '0;
        push(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        check_wb("t5_late_ack");
        chk("t5_req_late", 32'(dmem_req), 32'h0);

        // Test 6: back-to-back loads with immediate ack
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
            wn_in = 5'(10 + k); alu_in = 32'(32'h100 + k);
            push(1'b1, 1'b1, 5'(10 + k), 32'(32'hA000 + k), 32'(32'h100 + k));
            #1 chk("t6_idle_stall", 32'(stall), 32'h1);
            tick();
            dmem_ack = 1'b1; dmem_rdata = 32'(32'hA000 + k);
            #1 chk("t6_ack_stall", 32'(stall), 32'h0);
            tick();
            dmem_ack = 1'b0; dmem_rdata = '0;
            check_wb("t6_wb");
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
